// File: rtl/lcd_driver_pkg.sv
// Shared definitions for the LCD physical-layer driver: opcodes, LCD
// constants, init bytes, FSM encodings and the command decode helpers.
package lcd_driver_pkg;

    // Command opcodes carried in cmd_word[11:8]
    localparam logic [3:0] OP_CLEAR = 4'b0000;
    localparam logic [3:0] OP_WRITE = 4'b0001;
    localparam logic [3:0] OP_SETAD = 4'b0011;
    localparam logic [3:0] OP_WAIT1 = 4'b1111;
    localparam logic [3:0] OP_WAIT2 = 4'b0100;

    // Linear position -> DDRAM address mapping for a 2-line display
    localparam logic [7:0] LINE2_BASE  = 8'd40;
    localparam logic [7:0] LINE_END    = 8'd80;   // first position past line 2
    localparam logic [7:0] DDRAM_LINE2 = 8'h40;
    localparam logic [7:0] CMD_SETDD   = 8'h80;
    localparam logic [7:0] CMD_CLEAR   = 8'h01;

    // Power-up init bytes, sent in index order
    localparam logic [7:0] INIT_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8
    localparam logic [7:0] INIT_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] INIT_ENTRY    = 8'h06;  // increment, no shift
    localparam logic [7:0] INIT_CLEAR    = 8'h01;  // clear display
    localparam logic [1:0] INIT_LAST_IDX = 2'd3;

    typedef enum logic [3:0] {
        S_PWRUP,
        S_INIT_BUS,
        S_INIT_EXEC,
        S_RDY,
        S_FETCH1,
        S_FETCH2,
        S_DECODE,
        S_BUS,
        S_EXEC,
        S_DELAY
    } drv_state_e;

    typedef enum logic [1:0] {
        B_IDLE,
        B_SETUP,
        B_EHIGH,
        B_HOLD
    } bus_state_e;

    // Which wait length follows a command
    typedef enum logic [1:0] {
        W_CMD,
        W_CLEAR,
        W_POLL,
        W_LONG
    } wait_sel_e;

    typedef struct packed {
        logic      use_bus;
        logic      rs;
        logic [7:0] data;
        wait_sel_e wait_sel;
    } cmd_decode_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return INIT_FUNC_SET;
            2'd1:    return INIT_DISP_ON;
            2'd2:    return INIT_ENTRY;
            default: return INIT_CLEAR;
        endcase
    endfunction

    // Line 1 maps straight through, line 2 starts at DDRAM 0x40, anything
    // beyond the second line sends the cursor home.
    function automatic logic [7:0] setad_byte(input logic [7:0] pos);
        if (pos < LINE2_BASE) begin
            return CMD_SETDD | pos;
        end else if (pos < LINE_END) begin
            return CMD_SETDD | (DDRAM_LINE2 + (pos - LINE2_BASE));
        end else begin
            return CMD_SETDD;
        end
    endfunction

    function automatic cmd_decode_t decode_cmd(input logic [11:0] word);
        cmd_decode_t d;
        d.use_bus  = 1'b1;
        d.rs       = 1'b0;
        d.data     = word[7:0];
        d.wait_sel = W_CMD;
        case (word[11:8])
            OP_CLEAR: begin
                d.data     = CMD_CLEAR;
                d.wait_sel = W_CLEAR;
            end
            OP_WRITE: d.rs = 1'b1;
            OP_SETAD: d.data = setad_byte(word[7:0]);
            OP_WAIT2: begin
                d.use_bus  = 1'b0;
                d.wait_sel = W_LONG;
            end
            default: begin
                // WAIT1 and every unassigned opcode poll for T_POLL
                d.use_bus  = 1'b0;
                d.wait_sel = W_POLL;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lcd_driver_if.sv
// Command-generator / LCD pin bundle for the LCD driver.
//
// Handshake: rdy is a one-cycle advance strobe from the driver. Each rising
// edge of rdy consumes the current cmd_word; the generator must present the
// next word within two cycles of that edge, after which the driver samples
// it. There is no backpressure: the generator always has a word ready.
interface lcd_driver_if;
    logic [11:0] cmd_word;
    logic        rdy;
    logic        init_done;
    logic        lcd_e;
    logic        lcd_rs;
    logic        lcd_rw;
    logic [7:0]  lcd_data;

    modport master (
        output cmd_word,
        input  rdy, init_done, lcd_e, lcd_rs, lcd_rw, lcd_data
    );

    modport slave (
        input  cmd_word,
        output rdy, init_done, lcd_e, lcd_rs, lcd_rw, lcd_data
    );
endinterface

// File: rtl/lcd_driver_bus_cycle.sv
// One LCD write cycle: latches byte/rs on start, then SETUP (E low),
// EHIGH (E high), HOLD (E low). done pulses in the last HOLD cycle so the
// caller can move on with no gap cycle. Data and RS hold afterwards.
module lcd_driver_bus_cycle
    import lcd_driver_pkg::*;
#(
    parameter int unsigned T_AS = 4,
    parameter int unsigned T_EH = 16,
    parameter int unsigned T_AH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] data_i,
    input  logic       rs_i,
    output logic       done_o,
    output logic       lcd_e_o,
    output logic       lcd_rs_o,
    output logic [7:0] lcd_data_o,
    output bus_state_e state_o
);
    localparam int unsigned T_BMAX = max_u(max_u(T_AS, T_EH), T_AH);
    localparam int BW = (T_BMAX > 1) ? $clog2(T_BMAX) : 1;
    localparam logic [BW-1:0] AS_LAST = BW'(T_AS - 1);
    localparam logic [BW-1:0] EH_LAST = BW'(T_EH - 1);
    localparam logic [BW-1:0] AH_LAST = BW'(T_AH - 1);
    localparam logic [BW-1:0] CNT_ONE = BW'(1);

    bus_state_e    state_q, state_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic [7:0]    data_q, data_d;
    logic          rs_q, rs_d;

    // State, phase counter and latched pin values
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= B_IDLE;
            cnt_q   <= '0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
        end
    end

    // Phase sequencing; each phase lasts exactly its parameter in cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rs_d    = rs_q;
        done_o  = 1'b0;
        case (state_q)
            B_IDLE: begin
                if (start_i) begin
                    data_d  = data_i;
                    rs_d    = rs_i;
                    cnt_d   = '0;
                    state_d = B_SETUP;
                end
            end
            B_SETUP: begin
                if (cnt_q == AS_LAST) begin
                    cnt_d   = '0;
                    state_d = B_EHIGH;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            B_EHIGH: begin
                if (cnt_q == EH_LAST) begin
                    cnt_d   = '0;
                    state_d = B_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                if (cnt_q == AH_LAST) begin
                    cnt_d   = '0;
                    done_o  = 1'b1;
                    state_d = B_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    assign lcd_e_o    = (state_q == B_EHIGH);
    assign lcd_rs_o   = rs_q;
    assign lcd_data_o = data_q;
    assign state_o    = state_q;

endmodule

// File: rtl/lcd_driver.sv
// LCD physical-layer driver: power-up delay, four-byte init, then a
// request/fetch/decode/execute loop over 12-bit command words.
module lcd_driver
    import lcd_driver_pkg::*;
#(
    parameter int unsigned T_PWRUP = 750000,
    parameter int unsigned T_CMD   = 2000,
    parameter int unsigned T_CLEAR = 100000,
    parameter int unsigned T_POLL  = 1000,
    parameter int unsigned T_WAIT2 = 50000000,
    parameter int unsigned T_AS    = 4,
    parameter int unsigned T_EH    = 16,
    parameter int unsigned T_AH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    lcd_driver_if.slave bus,
    output drv_state_e  dbg_state_o,
    output bus_state_e  dbg_bus_state_o
);
    localparam int unsigned T_MAX =
        max_u(max_u(max_u(T_PWRUP, T_CMD), max_u(T_CLEAR, T_POLL)), T_WAIT2);
    localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(T_PWRUP - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(T_CLEAR - 1);
    localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(T_POLL - 1);
    localparam logic [CNT_W-1:0] WAIT2_LAST = CNT_W'(T_WAIT2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    drv_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       init_idx_q, init_idx_d;
    logic [11:0]      cmd_q, cmd_d;
    logic             init_done_q, init_done_d;

    cmd_decode_t      dec;
    logic [CNT_W-1:0] wait_last;
    logic [CNT_W-1:0] init_wait_last;
    logic             bus_start;
    logic             bus_rs;
    logic [7:0]       bus_data;
    logic             bus_done;

    // Decode the registered command and pick its wait length
    always_comb begin
        dec = decode_cmd(cmd_q);
        case (dec.wait_sel)
            W_CMD:   wait_last = CMD_LAST;
            W_CLEAR: wait_last = CLEAR_LAST;
            W_POLL:  wait_last = POLL_LAST;
            default: wait_last = WAIT2_LAST;
        endcase
    end

    // The clear-display init byte needs the long execution wait
    assign init_wait_last = (init_idx_q == INIT_LAST_IDX) ? CLEAR_LAST : CMD_LAST;

    // Main state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_PWRUP;
            cnt_q       <= '0;
            init_idx_q  <= 2'd0;
            cmd_q       <= 12'h000;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_idx_q  <= init_idx_d;
            cmd_q       <= cmd_d;
            init_done_q <= init_done_d;
        end
    end

    // Next-state logic; bus cycles are launched on the edge leaving the
    // preceding state so no idle cycle appears between phases
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_idx_d  = init_idx_q;
        cmd_d       = cmd_q;
        init_done_d = init_done_q;
        bus_start   = 1'b0;
        bus_data    = init_byte(init_idx_q);
        bus_rs      = 1'b0;
        case (state_q)
            S_PWRUP: begin
                if (cnt_q == PWRUP_LAST) begin
                    cnt_d     = '0;
                    bus_start = 1'b1;
                    state_d   = S_INIT_BUS;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_INIT_BUS: begin
                if (bus_done) begin
                    state_d = S_INIT_EXEC;
                end
            end
            S_INIT_EXEC: begin
                if (cnt_q == init_wait_last) begin
                    cnt_d = '0;
                    if (init_idx_q == INIT_LAST_IDX) begin
                        init_idx_d  = 2'd0;
                        init_done_d = 1'b1;
                        state_d     = S_RDY;
                    end else begin
                        init_idx_d = init_idx_q + 2'd1;
                        bus_start  = 1'b1;
                        bus_data   = init_byte(init_idx_q + 2'd1);
                        state_d    = S_INIT_BUS;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_RDY:    state_d = S_FETCH1;
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: begin
                // Generator updates on rdy's rising edge; sample two cycles on
                cmd_d   = bus.cmd_word;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (dec.use_bus) begin
                    bus_start = 1'b1;
                    bus_data  = dec.data;
                    bus_rs    = dec.rs;
                    state_d   = S_BUS;
                end else begin
                    state_d = S_DELAY;
                end
            end
            S_BUS: begin
                if (bus_done) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC, S_DELAY: begin
                if (cnt_q == wait_last) begin
                    cnt_d   = '0;
                    state_d = S_RDY;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = S_PWRUP;
        endcase
    end

    lcd_driver_bus_cycle #(
        .T_AS (T_AS),
        .T_EH (T_EH),
        .T_AH (T_AH)
    ) u_bus_cycle (
        .clk        (clk),
        .rst        (rst),
        .start_i    (bus_start),
        .data_i     (bus_data),
        .rs_i       (bus_rs),
        .done_o     (bus_done),
        .lcd_e_o    (bus.lcd_e),
        .lcd_rs_o   (bus.lcd_rs),
        .lcd_data_o (bus.lcd_data),
        .state_o    (dbg_bus_state_o)
    );

    // rdy is masked by rst so it can never be seen while reset is applied
    assign bus.rdy       = (state_q == S_RDY) && !rst;
    assign bus.init_done = init_done_q;
    assign bus.lcd_rw    = 1'b0;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_lcd_driver.sv
// Bench for lcd_driver with shortened timing parameters.
module tb_lcd_driver;
    import lcd_driver_pkg::*;

    localparam int T_PWRUP = 100;
    localparam int T_CMD   = 20;
    localparam int T_CLEAR = 50;
    localparam int T_POLL  = 10;
    localparam int T_WAIT2 = 200;
    localparam int T_AS    = 2;
    localparam int T_EH    = 4;
    localparam int T_AH    = 2;
    localparam int BUS_LEN = T_AS + T_EH + T_AH;
    localparam int INIT_CYC = T_PWRUP + 4 * BUS_LEN + 3 * T_CMD + T_CLEAR;
    localparam int LIMIT   = 400;
    localparam int N_VEC   = 14;
    localparam int N_RAND  = 40;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    drv_state_e dbg_state;
    bus_state_e dbg_bus_state;

    lcd_driver_if bus ();

    lcd_driver #(
        .T_PWRUP (T_PWRUP),
        .T_CMD   (T_CMD),
        .T_CLEAR (T_CLEAR),
        .T_POLL  (T_POLL),
        .T_WAIT2 (T_WAIT2),
        .T_AS    (T_AS),
        .T_EH    (T_EH),
        .T_AH    (T_AH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .dbg_state_o     (dbg_state),
        .dbg_bus_state_o (dbg_bus_state)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    // ---------------- counters / check helper ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- E-strobe monitor ----------------
    typedef struct {
        logic [8:0] rs_data;   // {rs, data}
        int         len;       // E-high cycles
        bit         stable;    // rs/data equal one cycle before, during and after E
    } burst_t;

    burst_t     burst_q[$];
    burst_t     cur;
    logic       e_prev  = 1'b0;
    logic [8:0] prev_rd = 9'h000;

    always @(posedge clk) begin
        #1;
        if (bus.lcd_e === 1'b1) begin
            if (e_prev !== 1'b1) begin
                cur.rs_data = {bus.lcd_rs, bus.lcd_data};
                cur.len     = 0;
                cur.stable  = (prev_rd === cur.rs_data);
            end
            cur.len = cur.len + 1;
            if ({bus.lcd_rs, bus.lcd_data} !== cur.rs_data) cur.stable = 1'b0;
        end else if (e_prev === 1'b1) begin
            if ({bus.lcd_rs, bus.lcd_data} !== cur.rs_data) cur.stable = 1'b0;
            burst_q.push_back(cur);
        end
        e_prev  = bus.lcd_e;
        prev_rd = {bus.lcd_rs, bus.lcd_data};
    end

    // ---------------- scoreboard ----------------
    logic [8:0] exp_q[$];

    task automatic drain(input string name);
        logic [8:0] e;
        burst_t     b;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (burst_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s missing_strobe: got none, expected byte %0h", name, e);
            end else begin
                b = burst_q.pop_front();
                check({name, " rs_data"}, 32'(b.rs_data), 32'(e));
                check({name, " e_width"}, b.len, T_EH);
                check({name, " setup_hold"}, 32'(b.stable), 32'd1);
            end
        end
        check({name, " extra_strobes"}, burst_q.size(), 0);
        burst_q.delete();
    endtask

    // ---------------- reference model ----------------
    task automatic model_cmd(input logic [11:0] w, output bit has_bus,
                             output logic [8:0] rd, output int gap);
        int arg;
        arg     = int'(w[7:0]);
        has_bus = 1'b1;
        rd      = 9'h000;
        gap     = 3 + BUS_LEN + T_CMD;
        case (w[11:8])
            4'h0: begin
                rd  = 9'h001;
                gap = 3 + BUS_LEN + T_CLEAR;
            end
            4'h1: rd = {1'b1, w[7:0]};
            4'h3: begin
                if (arg < 40)      rd = 9'(128 + arg);
                else if (arg < 80) rd = 9'(128 + 64 + (arg - 40));
                else               rd = 9'(128);
            end
            4'h4: begin
                has_bus = 1'b0;
                gap     = 3 + T_WAIT2;
            end
            default: begin
                has_bus = 1'b0;
                gap     = 3 + T_POLL;
            end
        endcase
    endtask

    // ---------------- driver tasks ----------------
    // Called right after rdy was seen high; presents the word and measures
    // the number of rdy-low cycles until the next pulse.
    task automatic run_cmd(input string name, input logic [11:0] word, input bit has_bus,
                           input logic [8:0] rd, input int exp_gap);
        int gap;
        bit got;
        if (has_bus) exp_q.push_back(rd);
        bus.cmd_word = word;
        gap = 0;
        got = 1'b0;
        while (!got && gap <= LIMIT) begin
            @(posedge clk);
            #1;
            if (bus.rdy === 1'b1) got = 1'b1;
            else gap++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no rdy within %0d cycles, expected after %0d", name, LIMIT, exp_gap);
        end else begin
            check({name, " rdy_gap"}, gap, exp_gap);
            check({name, " init_done"}, 32'(bus.init_done), 32'd1);
        end
        drain(name);
    endtask

    // Called right after rst was released; expects the full init sequence.
    task automatic run_init(input string name);
        int n;
        bit got;
        bit early;
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
        n     = 0;
        got   = 1'b0;
        early = 1'b0;
        while (!got && n <= INIT_CYC + LIMIT) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.rdy === 1'b1) got = 1'b1;
            else if (bus.init_done !== 1'b0) early = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no rdy after %0d cycles, expected at %0d", name, n, INIT_CYC);
        end else begin
            check({name, " first_rdy_cycle"}, n, INIT_CYC);
            check({name, " init_done_at_rdy"}, 32'(bus.init_done), 32'd1);
        end
        check({name, " init_done_early"}, 32'(early), 32'd0);
        drain(name);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [11:0] word;
        bit          has_bus;
        logic [8:0]  rd;
        int          gap;
    } vec_t;

    vec_t vecs[N_VEC];

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0]  op;
        logic [7:0]  arg;
        logic [11:0] w;
        bit          hb;
        logic [8:0]  rd;
        int          gap;
        int          n;
        bit          seen;

        vecs[0]  = '{12'h157, 1'b1, 9'h157, 31};  // WRITE 0x57
        vecs[1]  = '{12'h336, 1'b1, 9'h0CE, 31};  // SETAD 54
        vecs[2]  = '{12'h304, 1'b1, 9'h084, 31};  // SETAD 4
        vecs[3]  = '{12'h35A, 1'b1, 9'h080, 31};  // SETAD 90 -> home
        vecs[4]  = '{12'h327, 1'b1, 9'h0A7, 31};  // SETAD 39 end of line 1
        vecs[5]  = '{12'h328, 1'b1, 9'h0C0, 31};  // SETAD 40 start of line 2
        vecs[6]  = '{12'h34F, 1'b1, 9'h0E7, 31};  // SETAD 79 end of line 2
        vecs[7]  = '{12'h350, 1'b1, 9'h080, 31};  // SETAD 80 -> home
        vecs[8]  = '{12'hF33, 1'b0, 9'h000, 13};  // WAIT1
        vecs[9]  = '{12'h4A5, 1'b0, 9'h000, 203}; // WAIT2
        vecs[10] = '{12'hA00, 1'b0, 9'h000, 13};  // unassigned opcode
        vecs[11] = '{12'h0FF, 1'b1, 9'h001, 61};  // CLEAR
        vecs[12] = '{12'h2FF, 1'b0, 9'h000, 13};  // unassigned opcode
        vecs[13] = '{12'h1A5, 1'b1, 9'h1A5, 31};  // WRITE 0xA5

        bus.cmd_word = 12'h000;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset rdy", 32'(bus.rdy), 32'd0);
        check("reset init_done", 32'(bus.init_done), 32'd0);
        check("reset lcd_e", 32'(bus.lcd_e), 32'd0);
        check("reset lcd_rs", 32'(bus.lcd_rs), 32'd0);
        check("reset lcd_rw", 32'(bus.lcd_rw), 32'd0);
        check("reset lcd_data", 32'(bus.lcd_data), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        burst_q.delete();
        run_init("init");

        for (int i = 0; i < N_VEC; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].word, vecs[i].has_bus, vecs[i].rd, vecs[i].gap);
        end

        for (int i = 0; i < N_RAND; i++) begin
            case ($urandom_range(0, 5))
                0:       op = 4'h0;
                1:       op = 4'h1;
                2:       op = 4'h3;
                3:       op = 4'hF;
                4:       op = 4'h4;
                default: op = 4'($urandom_range(0, 15));
            endcase
            arg = (op == 4'h3) ? 8'($urandom_range(0, 100)) : 8'($urandom_range(0, 255));
            w = {op, arg};
            model_cmd(w, hb, rd, gap);
            run_cmd($sformatf("rand%0d_%03h", i, w), w, hb, rd, gap);
        end

        // Reset in the middle of a WRITE strobe: pins drop at once, init re-runs
        bus.cmd_word = 12'h157;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.lcd_e === 1'b1) seen = 1'b1;
        end
        check("midreset saw_e_high", 32'(seen), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset lcd_e", 32'(bus.lcd_e), 32'd0);
        check("midreset rdy", 32'(bus.rdy), 32'd0);
        check("midreset init_done", 32'(bus.init_done), 32'd0);
        check("midreset lcd_rs", 32'(bus.lcd_rs), 32'd0);
        check("midreset lcd_data", 32'(bus.lcd_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        burst_q.delete();
        exp_q.delete();
        run_init("reinit");
        run_cmd("post_reinit", 12'h336, 1'b1, 9'h0CE, 31);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
